// File: rtl/shift_pkg.sv
// Shared types and helpers for the serial shift stage and its receiver (shift_rx).
// Holds the receiver FSM state type, the default word width and a counter-width helper.
package shift_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam int SHIFT_BITS_DEF = 8;

  // Width of a counter or pointer that must index n distinct values; never below 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_rx_fifo.sv
// Small output FIFO for shift_rx: push/full write side, valid/ready read side.
// The head word is held in a register so o_dout stays steady while stalled and keeps the last popped word when empty.
module shift_rx_fifo
  import shift_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_dout
);

  localparam int PW = cnt_width(DEPTH);
  localparam int CW = cnt_width(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_dout;

  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  w_dout_nxt;

  assign w_pop  = (r_cnt != '0) && i_ready;
  assign w_full = (r_cnt == FULL_CNT);
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_wr   = i_push && (!w_full || w_pop);

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_cnt_nxt    = r_cnt;
    w_dout_nxt   = r_dout;
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end
    case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + ONE_CNT;
      2'b01:   w_cnt_nxt = r_cnt - ONE_CNT;
      default: w_cnt_nxt = r_cnt;
    endcase
    // Next head: the following stored entry, or the incoming word when it lands in an empty FIFO.
    if (w_pop) begin
      if (r_cnt > ONE_CNT) begin
        w_dout_nxt = r_mem[w_rd_ptr_nxt];
      end else if (w_wr) begin
        w_dout_nxt = i_din;
      end
    end else if ((r_cnt == '0) && w_wr) begin
      w_dout_nxt = i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dout   <= w_dout_nxt;
    end
  end

  assign o_full  = w_full;
  assign o_valid = (r_cnt != '0);
  assign o_dout  = r_dout;

endmodule

// File: rtl/shift_rx.sv
// Serial receiver: reassembles MSB-first words framed by eos, flags framing errors and buffers words in shift_rx_fifo.
// Optional saturating framing-error counter on err_cnt when SHIFT_RX_ERRCNT_EN is defined.
//   state | meaning
//   HUNT  | out of sync; discard bits until an eos marks a word boundary
//   RECV  | in sync; counting bits of the current word
module shift_rx
  import shift_pkg::*;
#(
  parameter int BITS  = SHIFT_BITS_DEF,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bit_vld,
  input  logic            sin,
  input  logic            eos,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            frm_err,
  output logic            ovf,
  output logic [7:0]      err_cnt
);

  localparam int BCW = cnt_width(BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS - 1);

  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic [BCW-1:0]  r_bit_cnt;
  logic [BCW-1:0]  w_bit_cnt_nxt;
  logic [BITS-2:0] r_sreg;
  logic [BITS-2:0] w_sreg_nxt;
  logic [BITS-1:0] w_word;
  logic            w_push;
  logic            w_frm_err;
  logic            r_frm_err;
  logic            r_ovf;
  logic            w_full;
  logic            w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUNT;
      r_bit_cnt <= '0;
      r_sreg    <= '0;
      r_frm_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sreg    <= w_sreg_nxt;
      r_frm_err <= w_frm_err;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sreg_nxt    = r_sreg;
    w_push        = 1'b0;
    w_frm_err     = 1'b0;
    w_word        = {r_sreg, sin};
    if (bit_vld) begin
      case (r_state)
        HUNT: begin
          if (eos) begin
            w_state_nxt   = RECV;
            w_bit_cnt_nxt = '0;
          end
        end
        RECV: begin
          w_sreg_nxt = w_word[BITS-2:0];
          if (eos) begin
            w_bit_cnt_nxt = '0;
            if (r_bit_cnt == LAST_BIT) begin
              w_push = 1'b1;
            end else begin
              w_frm_err = 1'b1;
            end
          end else if (r_bit_cnt == LAST_BIT) begin
            // Missing eos: boundary is lost, so wait for the next one.
            w_frm_err     = 1'b1;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = HUNT;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  shift_rx_fifo #(
    .W     (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_word),
    .o_full  (w_full),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_dout  (out_data)
  );

  assign w_drop = w_push && w_full && !(out_valid && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign frm_err = r_frm_err;
  assign ovf     = r_ovf;

`ifdef SHIFT_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'h00;
    end else if (w_frm_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
